// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: state encoding, parameter
// defaults and a one-hot to index helper.
package uart_pkg;

   localparam int N_REQ_DEF   = 4;
   localparam int TIMEOUT_DEF = 15;

   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [ST_W-1:0] ST_LAUNCH    = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd3;
   localparam logic [ST_W-1:0] ST_FLUSH     = 3'd4;

   function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-priority picker: first set request bit at or after (last+1) mod
// N_REQ, wrapping, returned one-hot with a valid flag.
module rr_select
   import uart_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       last,
   output logic [N_REQ-1:0] pick,
   output logic             vld
);

   logic [2:0]         shamt;
   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   rot;
   logic [N_REQ-1:0]   rot_pick;
   logic [2*N_REQ-1:0] pick_dbl;

   // Rotate so the highest-priority requester lands on bit 0, take the lowest
   // set bit, then rotate the one-hot result back into place.
   always_comb begin
      if (last >= 3'(N_REQ-1)) shamt = 3'd0;
      else                     shamt = last + 3'd1;
   end

   assign req_dbl = {req, req} >> shamt;
   assign rot     = req_dbl[N_REQ-1:0];

   always_comb begin
      rot_pick = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (rot[i]) rot_pick = '0;
         if (rot[i]) rot_pick[i] = 1'b1;
      end
   end

   assign pick_dbl = {rot_pick, rot_pick} << shamt;
   assign pick     = pick_dbl[2*N_REQ-1:N_REQ];
   assign vld      = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N_REQ byte sources into one UART transmitter,
// with a launch timeout on the transmitter's BUSY response.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | no transfer; grant the next requester on any REQ bit
//   LAUNCH     | START strobe to transmitter, byte held on TX_IN
//   WAIT_BUSY  | waiting for BUSY, down-counter aborts after TIMEOUT
//   WAIT_DONE  | frame in flight, waiting for DONE
//   FLUSH      | one cycle gap so DONE has cleared before next launch
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [N_REQ-1:0]   REQ,
   input  logic [N_REQ*8-1:0] REQ_DATA,
   output logic [N_REQ-1:0]   GNT,
   output logic [N_REQ-1:0]   SENT,
   output logic               ERR,
   output logic               START,
   output logic               TX_EN,
   output logic [7:0]         TX_IN,
   input  logic               BUSY,
   input  logic               DONE,
   output logic [2:0]         CUR_ID
);

   logic [ST_W-1:0]  state;
   logic [2:0]       last;
   logic [7:0]       launch_cnt;
   logic [N_REQ-1:0] pick;
   logic             pick_vld;
   logic [7:0]       pick_wide;
   logic [2:0]       pick_id;
   logic [7:0]       pick_byte;
   logic [N_REQ-1:0] sent_mask;

   rr_select #(.N_REQ(N_REQ)) u_rr_select (
      .req  (REQ),
      .last (last),
      .pick (pick),
      .vld  (pick_vld)
   );

   always_comb begin
      pick_wide = '0;
      pick_wide[N_REQ-1:0] = pick;
   end

   assign pick_id = onehot_idx(pick_wide);

   always_comb begin
      pick_byte = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) pick_byte = REQ_DATA[8*i +: 8];
      end
   end

   always_comb begin
      sent_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (CUR_ID == 3'(i)) sent_mask[i] = 1'b1;
      end
   end

   assign START = (state == ST_LAUNCH);
   assign TX_EN = (state != ST_IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         GNT        <= '0;
         SENT       <= '0;
         TX_IN      <= 8'd0;
         CUR_ID     <= 3'd0;
         ERR        <= 1'b0;
         launch_cnt <= 8'd0;
         last       <= 3'(N_REQ-1);
      end else begin
         GNT  <= '0;
         SENT <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  TX_IN  <= pick_byte;
                  CUR_ID <= pick_id;
                  last   <= pick_id;
                  GNT    <= pick;
                  state  <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               launch_cnt <= 8'(TIMEOUT);
               state      <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (BUSY) begin
                  launch_cnt <= 8'd0;
                  state      <= ST_WAIT_DONE;
               end else if (launch_cnt <= 8'd1) begin
                  // Transmitter never answered: drop the byte, no SENT.
                  launch_cnt <= 8'd0;
                  ERR        <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  launch_cnt <= launch_cnt - 8'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (DONE) begin
                  SENT  <= sent_mask;
                  state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART transmitter
// (BUSY for FRAME cycles after START, DONE on the last busy cycle).
module tb_uart_tx_arbiter;

   localparam int FRAME = 10;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [3:0]  REQ;
   logic [31:0] REQ_DATA;
   logic [3:0]  GNT;
   logic [3:0]  SENT;
   logic        ERR;
   logic        START;
   logic        TX_EN;
   logic [7:0]  TX_IN;
   logic        BUSY;
   logic        DONE;
   logic [2:0]  CUR_ID;

   logic        busy_kill;
   logic        done_inject;
   logic [4:0]  ucnt;
   logic [7:0]  ubyte;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0] oh;
      logic [7:0] data;
   } exp_t;

   exp_t gnt_q[$];
   exp_t sent_q[$];

   uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .REQ      (REQ),
      .REQ_DATA (REQ_DATA),
      .GNT      (GNT),
      .SENT     (SENT),
      .ERR      (ERR),
      .START    (START),
      .TX_EN    (TX_EN),
      .TX_IN    (TX_IN),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .CUR_ID   (CUR_ID)
   );

   always #5 CLK = ~CLK;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ucnt  <= '0;
         ubyte <= '0;
      end else if (START && TX_EN && ucnt == 0 && !busy_kill) begin
         ucnt  <= 5'(FRAME);
         ubyte <= TX_IN;
      end else if (ucnt != 0) begin
         ucnt <= ucnt - 5'd1;
      end
   end

   assign BUSY = (ucnt != 0) && !busy_kill;
   assign DONE = (ucnt == 5'd1) || done_inject;

   task automatic wait_gnt(input int budget, output int n, output bit seen, output bit sent_seen);
      n = 0; seen = 0; sent_seen = 0;
      while (!seen && n < budget) begin
         @(negedge CLK);
         n++;
         if (SENT != 0) sent_seen = 1;
         if (GNT != 0) seen = 1;
      end
   endtask

   task automatic wait_sent(input int budget, output int n, output bit seen, output bit gnt_seen);
      n = 0; seen = 0; gnt_seen = 0;
      while (!seen && n < budget) begin
         @(negedge CLK);
         n++;
         if (SENT != 0) begin
            seen = 1;
            if (GNT != 0) gnt_seen = 1;
         end
      end
   endtask

   task automatic do_reset();
      RST_N = 1'b0; REQ = '0; busy_kill = 0; done_inject = 0;
      gnt_q.delete(); sent_q.delete();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      exp_t e;
      int n; bit seen, ss;
      RST_N = 1'b0; busy_kill = 0; done_inject = 0;
      REQ = 4'b0110; REQ_DATA = 32'hAABBCCDD;
      repeat (3) @(negedge CLK);
      n_total++;
      if ({GNT, SENT, START, TX_EN, TX_IN, CUR_ID, ERR} !== '0)
         $display("FAIL reset_outputs: got %b expected all zero", {GNT, SENT, START, TX_EN, TX_IN, CUR_ID, ERR});
      else n_pass++;
      gnt_q.push_back('{4'b0010, 8'hCC});
      RST_N = 1'b1;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      n_total++;
      if (n !== 1) $display("FAIL reset_first_grant_latency: got %0d expected 1", n); else n_pass++;
      n_total++;
      if (GNT !== e.oh) $display("FAIL reset_first_grant: got %b expected %b", GNT, e.oh); else n_pass++;
      n_total++;
      if (TX_IN !== e.data) $display("FAIL reset_first_txin: got %h expected %h", TX_IN, e.data); else n_pass++;
      REQ = '0;
   endtask

   task automatic test_single();
      exp_t e;
      int n; bit seen, ss, gs;
      do_reset();
      REQ_DATA = 32'h000000_5A;
      gnt_q.push_back('{4'b0001, 8'h5A});
      sent_q.push_back('{4'b0001, 8'h5A});
      REQ = 4'b0001;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      n_total++;
      if (n !== 1) $display("FAIL single_latency: got %0d expected 1", n); else n_pass++;
      n_total++;
      if (GNT !== e.oh) $display("FAIL single_gnt: got %b expected %b", GNT, e.oh); else n_pass++;
      n_total++;
      if ({START, TX_EN} !== 2'b11) $display("FAIL single_start: got %b expected 11", {START, TX_EN}); else n_pass++;
      n_total++;
      if (TX_IN !== e.data) $display("FAIL single_txin: got %h expected %h", TX_IN, e.data); else n_pass++;
      REQ = '0;
      @(negedge CLK);
      n_total++;
      if ({GNT, START, TX_EN} !== 6'b0000_01) $display("FAIL single_pulse_width: got %b expected 000001", {GNT, START, TX_EN}); else n_pass++;
      wait_sent(40, n, seen, gs);
      e = sent_q.pop_front();
      n_total++;
      if (n !== FRAME) $display("FAIL single_sent_time: got %0d expected %0d", n, FRAME); else n_pass++;
      n_total++;
      if (SENT !== e.oh) $display("FAIL single_sent: got %b expected %b", SENT, e.oh); else n_pass++;
      n_total++;
      if (ubyte !== e.data || TX_IN !== e.data) $display("FAIL single_sent_byte: got %h/%h expected %h", ubyte, TX_IN, e.data); else n_pass++;
      @(negedge CLK);
      @(negedge CLK);
      n_total++;
      if ({SENT, TX_EN} !== 5'b0) $display("FAIL single_back_to_idle: got %b expected 00000", {SENT, TX_EN}); else n_pass++;
   endtask

   task automatic test_round_robin();
      exp_t e;
      int n; bit seen, ss, gs;
      logic [3:0] order_oh [5];
      logic [7:0] order_b  [5];
      order_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      order_b  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      do_reset();
      REQ_DATA = 32'h44332211;
      for (int i = 0; i < 5; i++) begin
         gnt_q.push_back('{order_oh[i], order_b[i]});
         sent_q.push_back('{order_oh[i], order_b[i]});
      end
      REQ = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(40, n, seen, ss);
         e = gnt_q.pop_front();
         if (i == 4) REQ = '0;
         n_total++;
         if (GNT !== e.oh || TX_IN !== e.data)
            $display("FAIL rr_grant_%0d: got %b/%h expected %b/%h", i, GNT, TX_IN, e.oh, e.data);
         else n_pass++;
         wait_sent(40, n, seen, gs);
         e = sent_q.pop_front();
         n_total++;
         if (SENT !== e.oh || ubyte !== e.data || gs !== 1'b0)
            $display("FAIL rr_sent_%0d: got %b/%h gnt_overlap %0d expected %b/%h 0", i, SENT, ubyte, gs, e.oh, e.data);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int n; bit seen, ss;
      do_reset();
      REQ_DATA = 32'h00C30000;
      for (int i = 0; i < 3; i++) gnt_q.push_back('{4'b0100, 8'hC3});
      REQ = 4'b0100;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      n_total++;
      if (GNT !== e.oh) $display("FAIL b2b_first: got %b expected %b", GNT, e.oh); else n_pass++;
      for (int i = 1; i < 3; i++) begin
         wait_gnt(40, n, seen, ss);
         e = gnt_q.pop_front();
         n_total++;
         if (n !== FRAME + 3) $display("FAIL b2b_spacing_%0d: got %0d expected %0d", i, n, FRAME + 3); else n_pass++;
         n_total++;
         if (GNT !== e.oh || TX_IN !== e.data)
            $display("FAIL b2b_grant_%0d: got %b/%h expected %b/%h", i, GNT, TX_IN, e.oh, e.data);
         else n_pass++;
      end
      REQ = '0;
   endtask

   task automatic test_timeout();
      exp_t e;
      int n; bit seen, ss, gs;
      bit err_early, sent_any;
      do_reset();
      busy_kill = 1;
      REQ_DATA = 32'h0000_6600;
      gnt_q.push_back('{4'b0010, 8'h66});
      REQ = 4'b0010;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      REQ = '0;
      n_total++;
      if (GNT !== e.oh) $display("FAIL timeout_grant: got %b expected %b", GNT, e.oh); else n_pass++;
      err_early = 0; sent_any = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge CLK);
         if (ERR) err_early = 1;
         if (SENT != 0) sent_any = 1;
      end
      n_total++;
      if (err_early !== 1'b0) $display("FAIL timeout_err_early: got %0d expected 0", err_early); else n_pass++;
      @(negedge CLK);
      if (SENT != 0) sent_any = 1;
      n_total++;
      if ({ERR, TX_EN} !== 2'b10) $display("FAIL timeout_err: got %b expected 10", {ERR, TX_EN}); else n_pass++;
      n_total++;
      if (sent_any !== 1'b0) $display("FAIL timeout_no_sent: got %0d expected 0", sent_any); else n_pass++;
      busy_kill = 0;
      REQ_DATA = 32'h0000_0077;
      gnt_q.push_back('{4'b0001, 8'h77});
      sent_q.push_back('{4'b0001, 8'h77});
      REQ = 4'b0001;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      REQ = '0;
      n_total++;
      if (GNT !== e.oh || TX_IN !== e.data) $display("FAIL timeout_regrant: got %b/%h expected %b/%h", GNT, TX_IN, e.oh, e.data); else n_pass++;
      wait_sent(40, n, seen, gs);
      e = sent_q.pop_front();
      n_total++;
      if (SENT !== e.oh || ERR !== 1'b1) $display("FAIL timeout_sticky: got %b/%0d expected %b/1", SENT, ERR, e.oh); else n_pass++;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int n; bit seen, ss, gs;
      do_reset();
      REQ_DATA = 32'h0000_3C00;
      REQ = 4'b0010;
      wait_gnt(5, n, seen, ss);
      REQ = '0;
      repeat (4) @(negedge CLK);
      n_total++;
      if ({TX_EN, BUSY} !== 2'b11) $display("FAIL rstmid_in_flight: got %b expected 11", {TX_EN, BUSY}); else n_pass++;
      #2 RST_N = 1'b0;
      #1;
      n_total++;
      if ({GNT, SENT, START, TX_EN, TX_IN, CUR_ID, ERR} !== '0)
         $display("FAIL rstmid_outputs: got %b expected all zero", {GNT, SENT, START, TX_EN, TX_IN, CUR_ID, ERR});
      else n_pass++;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      REQ_DATA = 32'h9900_0000;
      gnt_q.push_back('{4'b1000, 8'h99});
      sent_q.push_back('{4'b1000, 8'h99});
      REQ = 4'b1000;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      REQ = '0;
      n_total++;
      if (GNT !== e.oh || TX_IN !== e.data || CUR_ID !== 3'd3 || ss !== 1'b0)
         $display("FAIL rstmid_regrant: got %b/%h/%0d sent %0d expected %b/%h/3 sent 0", GNT, TX_IN, CUR_ID, ss, e.oh, e.data);
      else n_pass++;
      wait_sent(40, n, seen, gs);
      e = sent_q.pop_front();
      n_total++;
      if (SENT !== e.oh) $display("FAIL rstmid_sent: got %b expected %b", SENT, e.oh); else n_pass++;
   endtask

   task automatic test_reset_priority();
      exp_t e;
      int n; bit seen, ss;
      do_reset();
      REQ_DATA = 32'hB0_00_00_A0;
      REQ = 4'b0001;
      wait_gnt(5, n, seen, ss);
      REQ = '0;
      repeat (4) @(negedge CLK);
      #2 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      gnt_q.push_back('{4'b0001, 8'hA0});
      REQ = 4'b1001;
      wait_gnt(5, n, seen, ss);
      e = gnt_q.pop_front();
      REQ = '0;
      n_total++;
      if (GNT !== e.oh || TX_IN !== e.data) $display("FAIL rstprio_grant: got %b/%h expected %b/%h", GNT, TX_IN, e.oh, e.data); else n_pass++;
   endtask

   task automatic test_done_idle();
      bit moved;
      do_reset();
      moved = 0;
      done_inject = 1;
      @(negedge CLK);
      done_inject = 0;
      for (int i = 0; i < 4; i++) begin
         if ({GNT, SENT, START, TX_EN} != 0) moved = 1;
         @(negedge CLK);
      end
      n_total++;
      if (moved !== 1'b0) $display("FAIL done_in_idle: got activity %0d expected 0", moved); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_reset_priority();
      test_done_idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
